// File: rtl/rd_bus_arbiter.sv
// rd_bus_arbiter
//   Round-robin arbiter that shares one slave-side read bus among NM masters
//   speaking the Req/Valid/Addr/Sel/Last/Ready/Data read protocol. A master
//   keeps the grant for its whole burst (Req through the Last beat) plus one
//   DRAIN cycle, so the slave's registered read data still belongs to it.
//
// Optional build macro: RD_ARB_TIMEOUT_EN
//   When defined, a granted master that makes no transfer for TO_CYCLES
//   consecutive GRANT cycles loses the grant, and oTimeout pulses for 1 clk.
//
// Ports
//   iClk, iRst              clock, synchronous active-high reset
//   iMstRd{Req,Valid,Last}  per-master request / beat valid / last beat
//   iMstRdAddr, iMstRdSel   packed per-master address / select (master i at i*W)
//   oMstRdReady             slave ready, routed only to the granted master
//   oMstRdData              slave read data, broadcast unregistered
//   oBusRd*                 slave-side request/valid/addr/sel/last
//   iBusRdReady, iBusRdData slave ready and read data (data 1 clk after Ready)
//   oGrant                  registered one-hot grant
//   oTimeout                1-clk timeout pulse (RD_ARB_TIMEOUT_EN only)
//   oBusy                   high whenever the arbiter is not IDLE
module rd_bus_arbiter #(
    parameter int NM        = 4,
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int SW        = 4,
    parameter int TO_CYCLES = 64
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [NM-1:0]    iMstRdReq,
    input  logic [NM-1:0]    iMstRdValid,
    input  logic [NM*AW-1:0] iMstRdAddr,
    input  logic [NM*SW-1:0] iMstRdSel,
    input  logic [NM-1:0]    iMstRdLast,
    output logic [NM-1:0]    oMstRdReady,
    output logic [DW-1:0]    oMstRdData,
    output logic             oBusRdReq,
    output logic             oBusRdValid,
    output logic [AW-1:0]    oBusRdAddr,
    output logic [SW-1:0]    oBusRdSel,
    output logic             oBusRdLast,
    input  logic             iBusRdReady,
    input  logic [DW-1:0]    iBusRdData,
    output logic [NM-1:0]    oGrant,
`ifdef RD_ARB_TIMEOUT_EN
    output logic             oTimeout,
`endif
    output logic             oBusy
);

    localparam int IW = $clog2(NM);

    // Elaboration-time guard on the supported configuration range.
    if (NM < 2 || NM > 8 || TO_CYCLES < 1) begin : g_param_check
        $error("rd_bus_arbiter: NM must be 2..8 and TO_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_idx_q, last_idx_d;
    logic [AW-1:0]   hold_addr_q;
    logic [SW-1:0]   hold_sel_q;

    // Signals of the currently granted master.
    logic            g_req, g_valid, g_last;
    logic [AW-1:0]   g_addr;
    logic [SW-1:0]   g_sel;
    logic [IW-1:0]   g_idx;

    logic [NM-1:0]   pick_oh;
    logic            xfer;
    logic            to_fire;

    always_comb begin
        g_req   = 1'b0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_addr  = '0;
        g_sel   = '0;
        g_idx   = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant_q[i]) begin
                g_req   = iMstRdReq[i];
                g_valid = iMstRdValid[i];
                g_last  = iMstRdLast[i];
                g_addr  = iMstRdAddr[i*AW +: AW];
                g_sel   = iMstRdSel[i*SW +: SW];
                g_idx   = IW'(i);
            end
        end
    end

    // Round-robin pick: walk the scan order from lowest priority
    // (last_idx itself) to highest (last_idx+1), so the final hit wins.
    always_comb begin
        pick_oh = '0;
        for (int k = NM; k >= 1; k--) begin
            for (int j = 0; j < NM; j++) begin
                if (j == (int'(last_idx_q) + k) % NM && iMstRdReq[j]) begin
                    pick_oh    = '0;
                    pick_oh[j] = 1'b1;
                end
            end
        end
    end

    assign xfer = (state_q == GRANT) && g_valid && iBusRdReady;

`ifdef RD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    // Fires on the stall cycle that would bring the count to TO_CYCLES.
    assign to_fire = (state_q == GRANT) && !xfer && (cnt_q == CW'(TO_CYCLES - 1));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q    <= '0;
            oTimeout <= 1'b0;
        end else begin
            oTimeout <= to_fire;
            if (state_q != GRANT || xfer)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_idx_q  <= IW'(NM - 1);
            hold_addr_q <= '1;
            hold_sel_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            // Captured every beat so DRAIN shows the final beat's Addr/Sel
            // even if the master has already moved on.
            if (xfer) begin
                hold_addr_q <= g_addr;
                hold_sel_q  <= g_sel;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_idx_d  = last_idx_q;
        oBusRdReq   = 1'b0;
        oBusRdValid = 1'b0;
        oBusRdLast  = 1'b0;
        oBusRdAddr  = '1;
        oBusRdSel   = '0;
        oMstRdReady = '0;
        case (state_q)
            IDLE: begin
                if (|iMstRdReq) begin
                    grant_d = pick_oh;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                oBusRdReq   = g_req;
                oBusRdValid = g_valid;
                oBusRdLast  = g_last;
                oBusRdAddr  = g_addr;
                oBusRdSel   = g_sel;
                oMstRdReady = grant_q & {NM{iBusRdReady}};
                if (xfer && g_last) begin
                    state_d = DRAIN;
                end else if (!g_req || to_fire) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    last_idx_d = g_idx;
                end
            end
            DRAIN: begin
                oBusRdReq  = g_req;
                oBusRdAddr = hold_addr_q;
                oBusRdSel  = hold_sel_q;
                state_d    = IDLE;
                grant_d    = '0;
                last_idx_d = g_idx;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign oGrant     = grant_q;
    assign oBusy      = (state_q != IDLE);
    assign oMstRdData = iBusRdData;

endmodule

// File: tb/tb_rd_bus_arbiter.sv
// tb_rd_bus_arbiter
//   Directed scenarios (single burst, round-robin order, abort, reset in a
//   burst, optional timeout) followed by a randomized run of masters and a
//   stalling slave checked against a cycle-level model of the arbitration
//   rules. Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_rd_bus_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TOC = 8;
`ifdef RD_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             iClk = 1'b0;
    logic             iRst = 1'b1;
    logic [NM-1:0]    req  = '0;
    logic [NM-1:0]    vld  = '0;
    logic [NM-1:0]    lst  = '0;
    logic [AW-1:0]    m_addr [NM];
    logic [SW-1:0]    m_sel  [NM];
    logic [NM*AW-1:0] addr_p;
    logic [NM*SW-1:0] sel_p;
    logic             rdy   = 1'b0;
    logic [DW-1:0]    bdata = '0;

    logic [NM-1:0]    oMstRdReady;
    logic [DW-1:0]    oMstRdData;
    logic             oBusRdReq, oBusRdValid, oBusRdLast;
    logic [AW-1:0]    oBusRdAddr;
    logic [SW-1:0]    oBusRdSel;
    logic [NM-1:0]    oGrant;
    logic             oBusy;
`ifdef RD_ARB_TIMEOUT_EN
    logic             oTimeout;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 iClk = ~iClk;

    always_comb begin
        addr_p = '0;
        sel_p  = '0;
        for (int i = 0; i < NM; i++) begin
            addr_p[i*AW +: AW] = m_addr[i];
            sel_p[i*SW +: SW]  = m_sel[i];
        end
    end

    rd_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TO_CYCLES(TOC)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iMstRdReq   (req),
        .iMstRdValid (vld),
        .iMstRdAddr  (addr_p),
        .iMstRdSel   (sel_p),
        .iMstRdLast  (lst),
        .oMstRdReady (oMstRdReady),
        .oMstRdData  (oMstRdData),
        .oBusRdReq   (oBusRdReq),
        .oBusRdValid (oBusRdValid),
        .oBusRdAddr  (oBusRdAddr),
        .oBusRdSel   (oBusRdSel),
        .oBusRdLast  (oBusRdLast),
        .iBusRdReady (rdy),
        .iBusRdData  (bdata),
        .oGrant      (oGrant),
`ifdef RD_ARB_TIMEOUT_EN
        .oTimeout    (oTimeout),
`endif
        .oBusy       (oBusy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return {8'hD5, a, ~a};
    endfunction

    task automatic clear_masters();
        req = '0;
        vld = '0;
        lst = '0;
        for (int i = 0; i < NM; i++) begin
            m_addr[i] = '0;
            m_sel[i]  = '0;
        end
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        clear_masters();
        rdy = 1'b0;
        tick();
        tick();
        @(negedge iClk);
        chk("rst_state", {oGrant, oBusy}, '0);
        chk("rst_bus", {oBusRdReq, oBusRdValid, oBusRdLast, oBusRdSel, oMstRdReady, oBusRdAddr},
            {3'b000, 4'h0, 4'h0, 12'hFFF});
`ifdef RD_ARB_TIMEOUT_EN
        chk("rst_to", oTimeout, 1'b0);
`endif
        @(posedge iClk);
        #1;
        iRst = 1'b0;
    endtask

    // Random-phase state
    int            exp_own, exp_last, nx_own, nx_last, tcnt, nx_tcnt, stall, idx;
    bit            exp_drain, nx_drain, exp_to, nx_to, found, bus_beat;
    int            m_beats [NM];
    int            m_gap   [NM];
    bit            beat    [NM];
    bit            cap_pend[NM];
    logic [DW-1:0] cap_exp [NM];
    logic [AW-1:0] bus_a;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- single 4-beat burst from master 1
        do_reset();
        rdy = 1'b1;
        req[1] = 1'b1; vld[1] = 1'b1; m_addr[1] = 12'h100; m_sel[1] = 4'hF;
        @(negedge iClk);
        chk("sb_pre_grant", oGrant, 4'b0000);
        tick();
        for (int b = 0; b < 4; b++) begin
            m_addr[1] = AW'(12'h100 + 4 * b);
            lst[1]    = (b == 3);
            @(negedge iClk);
            chk("sb_grant", oGrant, 4'b0010);
            chk("sb_rdy", oMstRdReady, 4'b0010);
            chk("sb_addr", oBusRdAddr, 12'h100 + 4 * b);
            chk("sb_last", oBusRdLast, b == 3);
            chk("sb_sel", oBusRdSel, 4'hF);
            tick();
        end
        req[1] = 1'b0; vld[1] = 1'b0; lst[1] = 1'b0; m_addr[1] = 12'h7AB;
        @(negedge iClk);
        chk("sb_drain", {oGrant, oBusy, oBusRdValid, oMstRdReady}, {4'b0010, 1'b1, 1'b0, 4'b0000});
        chk("sb_drain_addr", oBusRdAddr, 12'h10C);
        tick();
        @(negedge iClk);
        chk("sb_idle", {oGrant, oBusy}, 5'b00000);
        chk("sb_idle_addr", oBusRdAddr, 12'hFFF);

        // ---------------- round-robin with all masters requesting 1-beat bursts
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < NM; i++) begin
            m_addr[i] = AW'(16 * (i + 1));
        end
        req = '1; vld = '1; lst = '1;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 10 && oGrant == '0; c++) @(negedge iClk);
            chk("rr_order", oGrant, 64'd1 << (k % NM));
            for (int c = 0; c < 10 && oGrant != '0; c++) @(negedge iClk);
            chk("rr_release", oGrant, 4'b0000);
        end

        // ---------------- abort: master 2 drops Req after 2 of 4 beats
        do_reset();
        rdy = 1'b1;
        req[2] = 1'b1; vld[2] = 1'b1; m_addr[2] = 12'h200;
        req[3] = 1'b1; vld[3] = 1'b1; m_addr[3] = 12'h300;
        tick();
        @(negedge iClk);
        chk("ab_grant2", oGrant, 4'b0100);
        tick();
        m_addr[2] = 12'h204;
        tick();
        req[2] = 1'b0; vld[2] = 1'b0;
        @(negedge iClk);
        chk("ab_still", oGrant, 4'b0100);
        tick();
        @(negedge iClk);
        chk("ab_idle", {oGrant, oBusy}, 5'b00000);
        tick();
        @(negedge iClk);
        chk("ab_grant3", oGrant, 4'b1000);

        // ---------------- reset during beat 2
        do_reset();
        rdy = 1'b1;
        req[2] = 1'b1; vld[2] = 1'b1; m_addr[2] = 12'h200;
        tick();
        @(negedge iClk);
        chk("rm_grant", oGrant, 4'b0100);
        tick();
        m_addr[2] = 12'h204;
        iRst = 1'b1;
        tick();
        @(negedge iClk);
        chk("rm_state", {oGrant, oBusy}, '0);
        chk("rm_bus", {oBusRdReq, oBusRdValid, oBusRdLast, oBusRdSel, oMstRdReady, oBusRdAddr},
            {3'b000, 4'h0, 4'h0, 12'hFFF});
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        req[0] = 1'b1; vld[0] = 1'b1; m_addr[0] = 12'h040;
        req[3] = 1'b1; vld[3] = 1'b1; m_addr[3] = 12'h300;
        @(negedge iClk);
        chk("rm_pre", oGrant, 4'b0000);
        tick();
        @(negedge iClk);
        chk("rm_first", oGrant, 4'b0001);

`ifdef RD_ARB_TIMEOUT_EN
        // ---------------- timeout: master 1 granted but never valid
        do_reset();
        rdy = 1'b1;
        req[1] = 1'b1; vld[1] = 1'b0; m_addr[1] = 12'h010;
        req[3] = 1'b1; vld[3] = 1'b1; lst[3] = 1'b1; m_addr[3] = 12'h300;
        tick();
        @(negedge iClk);
        chk("to_grant", {oGrant, oTimeout}, {4'b0010, 1'b0});
        for (int k = 1; k < TOC; k++) begin
            tick();
            @(negedge iClk);
            chk("to_quiet", oTimeout, 1'b0);
        end
        tick();
        @(negedge iClk);
        chk("to_pulse", {oGrant, oTimeout}, {4'b0000, 1'b1});
        tick();
        @(negedge iClk);
        chk("to_next", {oGrant, oTimeout}, {4'b1000, 1'b0});
`endif

        // ---------------- randomized run against the model
        do_reset();
        exp_own = -1; exp_last = NM - 1; exp_drain = 1'b0; exp_to = 1'b0; tcnt = 0; stall = 0;
        for (int i = 0; i < NM; i++) begin
            m_gap[i] = $urandom_range(0, 3);
            m_beats[i] = 0;
            cap_pend[i] = 1'b0;
        end
        rdy = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge iClk);
            chk("rnd_grant", oGrant, (exp_own >= 0) ? (64'd1 << exp_own) : 64'd0);
            chk("rnd_busy", oBusy, exp_own >= 0);
            if (exp_own >= 0 && !exp_drain) begin
                chk("rnd_addr", oBusRdAddr, m_addr[exp_own]);
                chk("rnd_ctl", {oBusRdReq, oBusRdValid, oBusRdLast, oBusRdSel},
                    {req[exp_own], vld[exp_own], lst[exp_own], m_sel[exp_own]});
                chk("rnd_rdy", oMstRdReady, rdy ? (64'd1 << exp_own) : 64'd0);
            end else if (exp_drain) begin
                chk("rnd_drain", {oBusRdValid, oMstRdReady}, '0);
            end else begin
                chk("rnd_idle", {oBusRdReq, oBusRdValid, oBusRdLast, oMstRdReady, oBusRdAddr},
                    {3'b000, 4'h0, 12'hFFF});
            end
`ifdef RD_ARB_TIMEOUT_EN
            chk("rnd_to", oTimeout, exp_to);
`endif
            for (int i = 0; i < NM; i++) begin
                if (cap_pend[i]) begin
                    chk("rnd_data", oMstRdData, cap_exp[i]);
                    cap_pend[i] = 1'b0;
                end
                beat[i] = oMstRdReady[i] && vld[i];
            end
            bus_beat = oBusRdValid && rdy;
            bus_a    = oBusRdAddr;

            // Model: what the arbitration rules say happens at the next edge.
            nx_own = exp_own; nx_last = exp_last; nx_drain = exp_drain; nx_tcnt = tcnt; nx_to = 1'b0;
            if (exp_own < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NM; k++) begin
                    idx = (exp_last + k) % NM;
                    if (!found && req[idx]) begin
                        nx_own = idx;
                        found  = 1'b1;
                    end
                end
                nx_tcnt = 0;
            end else if (exp_drain) begin
                nx_own = -1; nx_drain = 1'b0; nx_last = exp_own;
            end else begin
                nx_tcnt = (vld[exp_own] && rdy) ? 0 : tcnt + 1;
                nx_to   = TO_EN && (nx_tcnt == TOC);
                if (vld[exp_own] && rdy && lst[exp_own]) begin
                    nx_drain = 1'b1;
                end else if (!req[exp_own] || nx_to) begin
                    nx_own = -1; nx_last = exp_own;
                end
            end

            @(posedge iClk);
            #1;
            exp_own = nx_own; exp_last = nx_last; exp_drain = nx_drain; tcnt = nx_tcnt; exp_to = nx_to;
            bdata = bus_beat ? slave_data(bus_a) : DW'($urandom);
            for (int i = 0; i < NM; i++) begin
                if (beat[i]) begin
                    cap_pend[i] = 1'b1;
                    cap_exp[i]  = slave_data(m_addr[i]);
                    if (lst[i]) begin
                        req[i] = 1'b0; vld[i] = 1'b0; lst[i] = 1'b0;
                        m_gap[i] = $urandom_range(0, 3);
                    end else begin
                        m_addr[i] = m_addr[i] + AW'(4);
                        m_beats[i]--;
                        lst[i] = (m_beats[i] == 1);
                        vld[i] = ($urandom_range(0, 3) != 0);
                    end
                end else if (req[i]) begin
                    if ($urandom_range(0, 63) == 0) begin
                        req[i] = 1'b0; vld[i] = 1'b0; lst[i] = 1'b0;
                        m_gap[i] = $urandom_range(0, 3);
                    end else if (!vld[i]) begin
                        vld[i] = ($urandom_range(0, 3) != 0);
                    end
                end else if (m_gap[i] > 0) begin
                    m_gap[i]--;
                end else begin
                    m_beats[i] = $urandom_range(1, 4);
                    m_addr[i]  = AW'($urandom_range(0, 255) * 16);
                    m_sel[i]   = SW'($urandom);
                    req[i] = 1'b1;
                    vld[i] = ($urandom_range(0, 3) != 0);
                    lst[i] = (m_beats[i] == 1);
                end
            end
            if (stall > 0) begin
                stall--;
                rdy = 1'b0;
            end else if ($urandom_range(0, 31) == 0) begin
                stall = 4;
                rdy = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
